// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding plus load-use stall control for the 5-stage CPU.
// Stall length is LOAD_LAT bubbles; mem_busy freezes the pipeline and the stall FSM.
module hazard_forward_unit #(
   parameter int AW       = 5,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [AW-1:0]    id_rs,
   input  logic [AW-1:0]    id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [AW-1:0]    ex_rs,
   input  logic [AW-1:0]    ex_rt,
   input  logic [AW-1:0]    ex_wn,
   input  logic             ex_regwrite,
   input  logic             ex_memread,
   input  logic [AW-1:0]    mem_wn,
   input  logic             mem_regwrite,
   input  logic [AW-1:0]    wb_wn,
   input  logic             wb_regwrite,
   input  logic             mem_busy,
   output logic [1:0]       forward_a,
   output logic [1:0]       forward_b,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             idex_flush,
   output logic             stall_active,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             dbg_state
);

   typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [2:0]       rem_q, rem_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hz;
   logic             stall;

   function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src,
                                          input logic [AW-1:0] m_wn, input logic m_we,
                                          input logic [AW-1:0] w_wn, input logic w_we);
      logic [1:0] sel;
      sel = 2'b00;
      // EX/MEM holds the younger result, so it is checked first.
      if (m_we && (m_wn != '0) && (m_wn == src)) sel = 2'b10;
      else if (w_we && (w_wn != '0) && (w_wn == src)) sel = 2'b01;
      return sel;
   endfunction

   always_comb begin
      forward_a = 2'b00;
      forward_b = 2'b00;
      if (!reset) begin
         forward_a = fwd_sel(ex_rs, mem_wn, mem_regwrite, wb_wn, wb_regwrite);
         forward_b = fwd_sel(ex_rt, mem_wn, mem_regwrite, wb_wn, wb_regwrite);
      end
   end

   assign hz = ex_memread & ex_regwrite & (ex_wn != '0) &
               ((id_uses_rs & (ex_wn == id_rs)) | (id_uses_rt & (ex_wn == id_rt)));

   always_comb begin
      state_d      = state_q;
      rem_d        = rem_q;
      cnt_d        = cnt_q;
      stall        = 1'b0;
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      idex_flush   = 1'b0;
      stall_active = 1'b0;
      if (mem_busy) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (hz) begin
                  stall = 1'b1;
                  if (LOAD_LAT > 1) begin
                     state_d = HOLD;
                     rem_d   = 3'(LOAD_LAT - 1);
                  end
               end
            end
            HOLD: begin
               stall = 1'b1;
               rem_d = rem_q - 3'd1;
               if (rem_q == 3'd1) state_d = RUN;
            end
            default: state_d = RUN;
         endcase
      end
      if (stall) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_flush   = 1'b1;
         stall_active = 1'b1;
         if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
      // Reset is asynchronous, so the control outputs must not wait for an edge.
      if (reset) begin
         pc_write     = 1'b1;
         ifid_write   = 1'b1;
         idex_flush   = 1'b0;
         stall_active = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         rem_q   <= 3'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
      end
   end

   assign stall_cnt = cnt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: a LOAD_LAT=1/CNT_W=2 and a LOAD_LAT=3/CNT_W=16 instance
// share one set of inputs; each cycle's expected outputs are queued and checked at negedge.
module tb_hazard_forward_unit;

   localparam logic [3:0] R = 4'b1100;  // {pc_write, ifid_write, idex_flush, stall_active}
   localparam logic [3:0] S = 4'b0011;
   localparam logic [3:0] F = 4'b0000;

   typedef struct packed {
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic [3:0]  c1;
      logic [1:0]  n1;
      logic        s1;
      logic [3:0]  c3;
      logic [15:0] n3;
      logic        s3;
   } exp_t;
   localparam int EW = $bits(exp_t);

   logic          clk = 1'b0;
   logic          reset;
   logic [4:0]    id_rs, id_rt, ex_rs, ex_rt, ex_wn, mem_wn, wb_wn;
   logic          id_uses_rs, id_uses_rt, ex_regwrite, ex_memread;
   logic          mem_regwrite, wb_regwrite, mem_busy;

   logic [1:0]    fa1, fb1, fa3, fb3;
   logic          pc1, ifid1, fl1, sa1, st1;
   logic          pc3, ifid3, fl3, sa3, st3;
   logic [1:0]    cnt1;
   logic [15:0]   cnt3;

   logic [EW-1:0] exp_q[$];
   int            errors = 0;
   int            checks = 0;

   always #5 clk = ~clk;

   hazard_forward_unit #(.AW(5), .LOAD_LAT(1), .CNT_W(2)) u_lat1 (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_wn(ex_wn), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .mem_wn(mem_wn), .mem_regwrite(mem_regwrite), .wb_wn(wb_wn), .wb_regwrite(wb_regwrite),
      .mem_busy(mem_busy), .forward_a(fa1), .forward_b(fb1), .pc_write(pc1),
      .ifid_write(ifid1), .idex_flush(fl1), .stall_active(sa1), .stall_cnt(cnt1),
      .dbg_state(st1));

   hazard_forward_unit #(.AW(5), .LOAD_LAT(3), .CNT_W(16)) u_lat3 (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_wn(ex_wn), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .mem_wn(mem_wn), .mem_regwrite(mem_regwrite), .wb_wn(wb_wn), .wb_regwrite(wb_regwrite),
      .mem_busy(mem_busy), .forward_a(fa3), .forward_b(fb3), .pc_write(pc3),
      .ifid_write(ifid3), .idex_flush(fl3), .stall_active(sa3), .stall_cnt(cnt3),
      .dbg_state(st3));

   // Monitor: one expected entry per cycle, compared mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_t'(exp_q.pop_front());
         checks++;
         if ({fa1, fb1} !== {e.fa, e.fb}) begin
            errors++;
            $display("FAIL fwd_lat1 t=%0t got a=%b b=%b exp a=%b b=%b", $time, fa1, fb1, e.fa, e.fb);
         end
         checks++;
         if ({fa3, fb3} !== {e.fa, e.fb}) begin
            errors++;
            $display("FAIL fwd_lat3 t=%0t got a=%b b=%b exp a=%b b=%b", $time, fa3, fb3, e.fa, e.fb);
         end
         checks++;
         if ({pc1, ifid1, fl1, sa1, cnt1, st1} !== {e.c1, e.n1, e.s1}) begin
            errors++;
            $display("FAIL ctl_lat1 t=%0t got ctl=%b cnt=%0d st=%b exp ctl=%b cnt=%0d st=%b",
                     $time, {pc1, ifid1, fl1, sa1}, cnt1, st1, e.c1, e.n1, e.s1);
         end
         checks++;
         if ({pc3, ifid3, fl3, sa3, cnt3, st3} !== {e.c3, e.n3, e.s3}) begin
            errors++;
            $display("FAIL ctl_lat3 t=%0t got ctl=%b cnt=%0d st=%b exp ctl=%b cnt=%0d st=%b",
                     $time, {pc3, ifid3, fl3, sa3}, cnt3, st3, e.c3, e.n3, e.s3);
         end
      end
   end

   task automatic step(input logic [1:0] fa, input logic [1:0] fb,
                       input logic [3:0] c1, input logic [1:0] n1, input logic s1,
                       input logic [3:0] c3, input logic [15:0] n3, input logic s3);
      exp_t e;
      e = '{fa: fa, fb: fb, c1: c1, n1: n1, s1: s1, c3: c3, n3: n3, s3: s3};
      exp_q.push_back(EW'(e));
      @(posedge clk);
      #1;
   endtask

   task automatic set_hz(input logic on);
      ex_memread  = on;
      ex_regwrite = on;
      ex_wn       = 5'd5;
      id_rt       = 5'd5;
      id_uses_rt  = on;
      id_uses_rs  = 1'b0;
      id_rs       = 5'd0;
   endtask

   initial begin
      reset = 1'b1;
      {id_rs, id_rt, ex_rs, ex_rt, ex_wn, mem_wn, wb_wn} = '0;
      {id_uses_rs, id_uses_rt, ex_regwrite, ex_memread} = '0;
      {mem_regwrite, wb_regwrite, mem_busy} = '0;
      @(posedge clk);
      #1;
      // Reset holds RUN outputs and 00 selects even with a hazard and matching writers.
      mem_regwrite = 1'b1; wb_regwrite = 1'b1;
      mem_wn = 5'd3; wb_wn = 5'd3; ex_rs = 5'd3; ex_rt = 5'd3;
      set_hz(1'b1);
      step(2'b00, 2'b00, R, 2'd0, 1'b0, R, 16'd0, 1'b0);
      reset = 1'b0;
      set_hz(1'b0);
      step(2'b10, 2'b10, R, 2'd0, 1'b0, R, 16'd0, 1'b0);
      mem_regwrite = 1'b0;
      step(2'b01, 2'b01, R, 2'd0, 1'b0, R, 16'd0, 1'b0);
      mem_regwrite = 1'b1; mem_wn = 5'd0; wb_wn = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0;
      step(2'b00, 2'b00, R, 2'd0, 1'b0, R, 16'd0, 1'b0);
      mem_wn = 5'd3; ex_rs = 5'd3; wb_wn = 5'd4; ex_rt = 5'd4;
      step(2'b10, 2'b01, R, 2'd0, 1'b0, R, 16'd0, 1'b0);
      // Load whose target matches only an unused source, then a load to r0.
      ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wn = 5'd6;
      id_rs = 5'd6; id_uses_rs = 1'b0; id_rt = 5'd0; id_uses_rt = 1'b1;
      step(2'b10, 2'b01, R, 2'd0, 1'b0, R, 16'd0, 1'b0);
      ex_wn = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
      step(2'b10, 2'b01, R, 2'd0, 1'b0, R, 16'd0, 1'b0);
      // Plain load-use hazard.
      set_hz(1'b1);
      step(2'b10, 2'b01, S, 2'd0, 1'b0, S, 16'd0, 1'b0);
      set_hz(1'b0);
      step(2'b10, 2'b01, R, 2'd1, 1'b0, S, 16'd1, 1'b1);
      step(2'b10, 2'b01, R, 2'd1, 1'b0, S, 16'd2, 1'b1);
      step(2'b10, 2'b01, R, 2'd1, 1'b0, R, 16'd3, 1'b0);
      // Freeze for two cycles inside HOLD.
      set_hz(1'b1);
      step(2'b10, 2'b01, S, 2'd1, 1'b0, S, 16'd3, 1'b0);
      set_hz(1'b0);
      mem_busy = 1'b1;
      step(2'b10, 2'b01, F, 2'd2, 1'b0, F, 16'd4, 1'b1);
      step(2'b10, 2'b01, F, 2'd2, 1'b0, F, 16'd4, 1'b1);
      mem_busy = 1'b0;
      step(2'b10, 2'b01, R, 2'd2, 1'b0, S, 16'd4, 1'b1);
      step(2'b10, 2'b01, R, 2'd2, 1'b0, S, 16'd5, 1'b1);
      step(2'b10, 2'b01, R, 2'd2, 1'b0, R, 16'd6, 1'b0);
      // Hazard arriving while frozen waits for mem_busy to drop.
      set_hz(1'b1);
      mem_busy = 1'b1;
      step(2'b10, 2'b01, F, 2'd2, 1'b0, F, 16'd6, 1'b0);
      mem_busy = 1'b0;
      step(2'b10, 2'b01, S, 2'd2, 1'b0, S, 16'd6, 1'b0);
      set_hz(1'b0);
      step(2'b10, 2'b01, R, 2'd3, 1'b0, S, 16'd7, 1'b1);
      // Further hazards saturate the 2-bit counter at 3.
      set_hz(1'b1);
      step(2'b10, 2'b01, S, 2'd3, 1'b0, S, 16'd8, 1'b1);
      set_hz(1'b0);
      step(2'b10, 2'b01, R, 2'd3, 1'b0, R, 16'd9, 1'b0);
      set_hz(1'b1);
      step(2'b10, 2'b01, S, 2'd3, 1'b0, S, 16'd9, 1'b0);
      set_hz(1'b0);
      step(2'b10, 2'b01, R, 2'd3, 1'b0, S, 16'd10, 1'b1);
      // Reset raised mid-HOLD, sampled before any clock edge.
      reset = 1'b1;
      step(2'b00, 2'b00, R, 2'd0, 1'b0, R, 16'd0, 1'b0);
      reset = 1'b0;
      step(2'b10, 2'b01, R, 2'd0, 1'b0, R, 16'd0, 1'b0);
      set_hz(1'b1);
      step(2'b10, 2'b01, S, 2'd0, 1'b0, S, 16'd0, 1'b0);
      set_hz(1'b0);
      step(2'b10, 2'b01, R, 2'd1, 1'b0, S, 16'd1, 1'b1);

      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending exp 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
